seq_comp: RTL and testbench

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands chunk by chunk, most-significant chunk first, and supports signed and unsigned modes. The comparison ends early at the first chunk that differs. The block sits beside the sequence multiplier datapath, where a wide single-cycle subtract-based compare does not meet timing. It uses valid/ready handshakes on both the operand side and the result side.

---
 rtl/seq_comp.sv | 133 +++++++++++++
 tb/tb_seq_comp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_comp.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands CHUNK bits
// per cycle, most-significant chunk first, exiting at the first differing chunk.
module seq_comp #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic             signed_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             less_o,
   output logic             equal_o
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [WIDTH-1:0]  a_reg, a_next;
   logic [WIDTH-1:0]  b_reg, b_next;
   logic [KW-1:0]     k_reg, k_next;
   logic              less_reg, less_next;
   logic              equal_reg, equal_next;

   // Chunk 0 is the most-significant slice of each operand.
   logic [CHUNK-1:0]  a_chunk [N];
   logic [CHUNK-1:0]  b_chunk [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chunk
         assign a_chunk[gi] = a_reg[WIDTH-1-gi*CHUNK -: CHUNK];
         assign b_chunk[gi] = b_reg[WIDTH-1-gi*CHUNK -: CHUNK];
      end
   endgenerate

   logic [CHUNK:0]    diff;
   logic              borrow;
   logic              diff_zero;
   logic              last_chunk;

   assign diff       = {1'b0, a_chunk[k_reg]} - {1'b0, b_chunk[k_reg]};
   assign borrow     = diff[CHUNK];
   assign diff_zero  = (diff[CHUNK-1:0] == '0);
   assign last_chunk = (k_reg == KW'(N - 1));

   // Flipping the MSB of both operands maps two's-complement order onto unsigned order.
   logic [WIDTH-1:0]  bias;
   assign bias = {signed_i, {(WIDTH-1){1'b0}}};

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      k_next     = k_reg;
      less_next  = less_reg;
      equal_next = equal_reg;
      unique case (state_reg)
         IDLE: begin
            if (valid_i) begin
               a_next     = operand_a_i ^ bias;
               b_next     = operand_b_i ^ bias;
               k_next     = '0;
               state_next = CMP;
            end
         end
         CMP: begin
            if (borrow) begin
               less_next  = 1'b1;
               equal_next = 1'b0;
               state_next = DONE;
            end else if (!diff_zero) begin
               less_next  = 1'b0;
               equal_next = 1'b0;
               state_next = DONE;
            end else if (last_chunk) begin
               less_next  = 1'b0;
               equal_next = 1'b1;
               state_next = DONE;
            end else begin
               k_next = k_reg + KW'(1);
            end
         end
         DONE: begin
            if (ready_i) begin
               less_next  = 1'b0;
               equal_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            less_next  = 1'b0;
            equal_next = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         k_reg     <= '0;
         less_reg  <= 1'b0;
         equal_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         k_reg     <= k_next;
         less_reg  <= less_next;
         equal_reg <= equal_next;
      end
   end

   assign ready_o = (state_reg == IDLE);
   assign valid_o = (state_reg == DONE);
   assign less_o  = less_reg;
   assign equal_o = equal_reg;

endmodule

// File: tb/tb_seq_comp.sv
// Directed and randomised checks of seq_comp at WIDTH=16, CHUNK=4.
module tb_seq_comp;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int N     = WIDTH / CHUNK;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] operand_a_i;
   logic [WIDTH-1:0] operand_b_i;
   logic             signed_i;
   logic             valid_o;
   logic             ready_i;
   logic             less_o;
   logic             equal_o;

   int n_checks = 0;
   int n_fails  = 0;

   seq_comp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .signed_i    (signed_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .less_o      (less_o),
      .equal_o     (equal_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // Present operands in IDLE, return cycles from accept edge to valid_o.
   task automatic start_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, output int lat);
      @(negedge clk_i);
      operand_a_i = a;
      operand_b_i = b;
      signed_i    = s;
      valid_i     = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i     = 1'b0;
      operand_a_i = ~a;
      operand_b_i = ~b;
      signed_i    = ~s;
      lat = 0;
      while (!valid_o && lat < N + 3) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
   endtask

   task automatic run_cmp(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic s,
                          input logic exp_less, input logic exp_eq, input int exp_lat);
      int lat;
      start_and_wait(a, b, s, lat);
      $display("txn %s a=%h b=%h signed=%0b lat=%0d less=%0b eq=%0b",
               tag, a, b, s, lat, less_o, equal_o);
      check({tag, ".lat"},   lat,     exp_lat);
      check({tag, ".less"},  less_o,  exp_less);
      check({tag, ".equal"}, equal_o, exp_eq);
      @(posedge clk_i);
      #1;
      check({tag, ".valid_drop"}, valid_o, 0);
      check({tag, ".ready_back"}, ready_o, 1);
   endtask

   task automatic ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, output logic l, output logic e, output int lat);
      e = (a == b);
      l = s ? ($signed(a) < $signed(b)) : (a < b);
      lat = N;
      for (int c = N - 1; c >= 0; c--) begin
         if (a[c*CHUNK +: CHUNK] != b[c*CHUNK +: CHUNK]) begin
            lat = N - c;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      logic l0, e0, v0;
      logic el, ee;
      int   elat;
      logic [WIDTH-1:0] ra, rb;
      logic rs;

      rst_i = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      operand_a_i = '0;
      operand_b_i = '0;
      signed_i = 1'b0;
      #12;
      check("reset.ready", ready_o, 1);
      check("reset.valid", valid_o, 0);
      check("reset.less",  less_o,  0);
      check("reset.equal", equal_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      run_cmp("eq_1234",   16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 4);
      run_cmp("lt_0fff",   16'h0FFF, 16'h1000, 1'b0, 1'b1, 1'b0, 1);
      run_cmp("s_ffff",    16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0, 1);
      run_cmp("u_ffff",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
      run_cmp("s_8000",    16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1);
      run_cmp("gt_1235",   16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, 4);
      run_cmp("lt_1233",   16'h1233, 16'h1234, 1'b0, 1'b1, 1'b0, 4);

      // Back-pressure with busy-time requests that must be ignored.
      ready_i = 1'b0;
      @(negedge clk_i);
      operand_a_i = 16'h1200;
      operand_b_i = 16'h1300;
      signed_i    = 1'b0;
      valid_i     = 1'b1;
      @(posedge clk_i);
      #1;
      operand_a_i = 16'h0000;
      operand_b_i = 16'hFFFF;
      check("bp.cmp_ready", ready_o, 0);
      lat = 0;
      while (!valid_o && lat < N + 3) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      $display("txn bp a=1200 b=1300 lat=%0d less=%0b eq=%0b", lat, less_o, equal_o);
      check("bp.lat",  lat,    2);
      check("bp.less", less_o, 1);
      l0 = less_o;
      e0 = equal_o;
      v0 = valid_o;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #1;
         check("bp.hold_valid", valid_o, v0);
         check("bp.hold_less",  less_o,  l0);
         check("bp.hold_equal", equal_o, e0);
         check("bp.done_ready", ready_o, 0);
      end
      valid_i = 1'b0;
      @(negedge clk_i);
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("bp.release_ready", ready_o, 1);
      check("bp.release_valid", valid_o, 0);
      check("bp.release_less",  less_o,  0);

      // Asynchronous reset in the middle of a compare.
      @(negedge clk_i);
      operand_a_i = 16'h1234;
      operand_b_i = 16'h1234;
      signed_i    = 1'b0;
      valid_i     = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      $display("txn reset_mid_cmp ready=%0b valid=%0b", ready_o, valid_o);
      check("arst.ready", ready_o, 1);
      check("arst.valid", valid_o, 0);
      check("arst.less",  less_o,  0);
      check("arst.equal", equal_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("arst.no_pulse", valid_o, 0);
      run_cmp("post_rst", 16'h4321, 16'h4322, 1'b0, 1'b1, 1'b0, 4);

      // Randomised operands; bias the draw so long equal prefixes occur.
      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = ra;
         case (i % 4)
            0: rb = 16'($urandom);
            1: rb[3:0] = 4'($urandom);
            2: rb[11:8] = 4'($urandom);
            default: rb = ra;
         endcase
         rs = 1'($urandom);
         ref_model(ra, rb, rs, el, ee, elat);
         run_cmp($sformatf("rnd%0d", i), ra, rb, rs, el, ee, elat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
